// File: rtl/poisson_spike_encoder_if.sv
// Pixel-stream input and spike-vector output bundle of the Poisson rate encoder.
// master = encoder side, slave = image source / neuron-layer side.
interface poisson_spike_encoder_if #(
  parameter int NUM_INPUTS  = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_STEPS   = 350
);
  localparam int TS_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                   pixel_valid;
  logic                   pixel_ready;
  logic [PIXEL_WIDTH-1:0] pixel_data;
  logic                   start;
  logic [NUM_INPUTS-1:0]  spike_out;
  logic                   spike_valid;
  logic                   spike_ready;
  logic [TS_W-1:0]        timestep;
  logic                   busy;
  logic                   done;

  modport master (
    input  pixel_valid, pixel_data, start, spike_ready,
    output pixel_ready, spike_out, spike_valid, timestep, busy, done
  );

  modport slave (
    output pixel_valid, pixel_data, start, spike_ready,
    input  pixel_ready, spike_out, spike_valid, timestep, busy, done
  );
endinterface

// File: rtl/poisson_spike_encoder.sv
// Poisson rate encoder: stores one image, then per timestep compares every pixel
// against a Galois LFSR byte and presents the resulting spike vector. NUM_INPUTS >= 2.
module poisson_spike_encoder #(
  parameter int                    NUM_INPUTS  = 784,
  parameter int                    PIXEL_WIDTH = 8,
  parameter int                    NUM_STEPS   = 350,
  parameter int                    LFSR_WIDTH  = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  poisson_spike_encoder_if.master  io
);
  localparam int TS_W  = (NUM_STEPS  > 1) ? $clog2(NUM_STEPS)  : 1;
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [LFSR_WIDTH-1:0] SEED     = (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [TS_W-1:0]       LAST_TS  = TS_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {S_LOAD, S_ARMED, S_GEN, S_PRESENT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_step;
  logic [NUM_INPUTS-1:0]  buf_q, buf_d;
  logic [NUM_INPUTS-1:0]  spike_out_q, spike_out_d;
  logic                   spike_valid_q, spike_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pixel_ready_q, pixel_ready_d;
  logic                   pix_we;
  logic                   cmp;
  logic [PIXEL_WIDTH-1:0] pix_q [NUM_INPUTS];

  assign lfsr_step = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign cmp       = lfsr_q[PIXEL_WIDTH-1:0] < pix_q[idx_q];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ts_d          = ts_q;
    lfsr_d        = lfsr_q;
    buf_d         = buf_q;
    spike_out_d   = spike_out_q;
    spike_valid_d = spike_valid_q;
    done_d        = 1'b0;
    pix_we        = 1'b0;
    case (state_q)
      S_LOAD: if (io.pixel_valid) begin
        pix_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_ARMED;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_ARMED: if (io.start) begin
        ts_d    = '0;
        state_d = S_GEN;
      end
      S_GEN: begin
        // pixel 0 is shifted in first, so after NUM_INPUTS shifts bit i = pixel i
        lfsr_d = lfsr_step;
        buf_d  = {cmp, buf_q[NUM_INPUTS-1:1]};
        if (idx_q == LAST_IDX) begin
          idx_d         = '0;
          state_d       = S_PRESENT;
          spike_valid_d = 1'b1;
          spike_out_d   = buf_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_PRESENT: if (io.spike_ready) begin
        spike_valid_d = 1'b0;
        spike_out_d   = '0;
        if (ts_q == LAST_TS) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          ts_d    = ts_q + 1'b1;
          state_d = S_GEN;
        end
      end
      S_DONE: begin
        ts_d    = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
    busy_d        = (state_d == S_GEN) || (state_d == S_PRESENT);
    pixel_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      idx_q         <= '0;
      ts_q          <= '0;
      lfsr_q        <= SEED;
      buf_q         <= '0;
      spike_out_q   <= '0;
      spike_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pixel_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ts_q          <= ts_d;
      lfsr_q        <= lfsr_d;
      buf_q         <= buf_d;
      spike_out_q   <= spike_out_d;
      spike_valid_q <= spike_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pixel_ready_q <= pixel_ready_d;
    end
  end

  // Image store has no reset; a full LOAD always precedes any read.
  always_ff @(posedge clk) begin
    if (pix_we && !rst) pix_q[idx_q] <= io.pixel_data;
  end

  assign io.pixel_ready = pixel_ready_q;
  assign io.spike_out   = spike_out_q;
  assign io.spike_valid = spike_valid_q;
  assign io.timestep    = ts_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;
endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Directed bench for poisson_spike_encoder with a Galois-LFSR reference model
// feeding a queue of expected spike vectors.
module tb_poisson_spike_encoder;
  localparam int          N     = 16;
  localparam int          PW    = 8;
  localparam int          NS    = 8;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          BOUND = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poisson_spike_encoder_if #(.NUM_INPUTS(N), .PIXEL_WIDTH(PW), .NUM_STEPS(NS)) io ();

  poisson_spike_encoder #(
    .NUM_INPUTS(N), .PIXEL_WIDTH(PW), .NUM_STEPS(NS), .LFSR_WIDTH(16),
    .LFSR_TAPS(TAPS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int             n_cmp = 0;
  int             n_bad = 0;
  int             ones_total;
  logic [N-1:0]   exp_q[$];
  logic [15:0]    m_lfsr;
  logic [PW-1:0]  img [N];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0);
  endfunction

  task automatic push_expected();
    logic [N-1:0] v;
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < N; i++) begin
        v[i]   = (m_lfsr[PW-1:0] < img[i]);
        m_lfsr = lstep(m_lfsr);
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic load_image(input bit start_noise);
    io.pixel_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      io.pixel_data = img[i];
      io.start      = start_noise && (i % 2 == 1);
      chk("load_ready", io.pixel_ready, 1);
      chk("load_busy", io.busy, 0);
      tick();
    end
    io.pixel_valid = 1'b0;
    io.start       = 1'b0;
    chk("armed_ready", io.pixel_ready, 0);
  endtask

  task automatic run_image(input int stall, input bit gen_noise, input int abort_ts);
    int           cnt;
    logic [N-1:0] exp;
    push_expected();
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    for (int s = 0; s < NS; s++) begin
      chk("gen_busy", io.busy, 1);
      chk("gen_pixel_ready", io.pixel_ready, 0);
      if (gen_noise) begin
        io.pixel_valid = 1'b1;
        io.pixel_data  = 8'hA5;
        io.spike_ready = 1'b1;
      end
      cnt = 0;
      while (!io.spike_valid && cnt < BOUND) begin
        tick();
        cnt++;
      end
      io.pixel_valid = 1'b0;
      io.spike_ready = 1'b0;
      chk("latency", cnt, N);
      chk("timestep", io.timestep, s);
      exp = exp_q.pop_front();
      chk("spike_out", io.spike_out, exp);
      ones_total += $countones(io.spike_out);
      if (s == abort_ts) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", io.spike_valid, 0);
        chk("rst_out", io.spike_out, 0);
        chk("rst_busy", io.busy, 0);
        chk("rst_ts", io.timestep, 0);
        chk("rst_pixel_ready", io.pixel_ready, 1);
        chk("rst_done", io.done, 0);
        exp_q.delete();
        m_lfsr = SEED;
        return;
      end
      if (s == 0) begin
        for (int k = 0; k < stall; k++) begin
          tick();
          chk("stall_out", io.spike_out, exp);
          chk("stall_valid", io.spike_valid, 1);
          chk("stall_ts", io.timestep, 0);
        end
      end
      io.spike_ready = 1'b1;
      tick();
      io.spike_ready = 1'b0;
      chk("acc_valid", io.spike_valid, 0);
      chk("acc_out", io.spike_out, 0);
      chk("done_pulse", io.done, (s == NS - 1));
      if (s == NS - 1) begin
        tick();
        chk("done_clear", io.done, 0);
        chk("post_pixel_ready", io.pixel_ready, 1);
        chk("post_ts", io.timestep, 0);
        chk("post_busy", io.busy, 0);
      end
    end
  endtask

  initial begin
    io.pixel_valid = 1'b0;
    io.pixel_data  = '0;
    io.start       = 1'b0;
    io.spike_ready = 1'b0;
    m_lfsr         = SEED;
    ones_total     = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", io.spike_valid, 0);
    chk("reset_out", io.spike_out, 0);
    chk("reset_busy", io.busy, 0);
    chk("reset_done", io.done, 0);
    chk("reset_pixel_ready", io.pixel_ready, 1);
    chk("reset_ts", io.timestep, 0);

    // all-zero image, start pulses during LOAD, junk pixels while ARMED
    for (int i = 0; i < N; i++) img[i] = '0;
    load_image(1'b1);
    io.pixel_valid = 1'b1;
    io.pixel_data  = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("armed_wait_ready", io.pixel_ready, 0);
      chk("armed_wait_busy", io.busy, 0);
      chk("armed_wait_valid", io.spike_valid, 0);
    end
    io.pixel_valid = 1'b0;
    run_image(0, 1'b0, -1);

    // saturated image
    for (int i = 0; i < N; i++) img[i] = 8'hFF;
    ones_total = 0;
    load_image(1'b0);
    run_image(0, 1'b0, -1);
    chk("ones_255", (ones_total >= (N * NS * 99) / 100), 1);

    // ramp with a 10-cycle stall and bus noise during GEN
    for (int i = 0; i < N; i++) img[i] = PW'(i % 256);
    load_image(1'b0);
    run_image(10, 1'b1, -1);

    // reset in PRESENT halfway through
    load_image(1'b0);
    run_image(0, 1'b0, NS / 2);

    // two back-to-back random images, LFSR continues from the post-reset seed
    for (int i = 0; i < N; i++) img[i] = PW'($urandom_range(0, 255));
    load_image(1'b0);
    run_image(0, 1'b0, -1);
    for (int i = 0; i < N; i++) img[i] = PW'($urandom_range(0, 255));
    load_image(1'b0);
    run_image(0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
